// File: rtl/serial_pkg.sv
// Shared types and constants for the memory-mapped serial transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/serial_if.sv
// CPU data-memory bus slice seen by the serial port (already qualified by the Mmu sel decode).
// Handshake: a store acts on every clock edge where sel&we; a load on every edge where sel&re,
// with dout valid from the following edge and held until the next load. No backpressure.
interface serial_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, we, re, addr, din, input dout);
  modport slave  (input sel, we, re, addr, din, output dout);
endinterface

// File: rtl/serial_fifo.sv
// Synchronous FIFO with show-ahead read data; DEPTH must be a power of two.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_tx.sv
// UART transmitter: DATA/STATUS register decode, TX FIFO and 8N1 framer.
// Define SERIAL_PARITY_EN to insert an even-parity bit (8E1 framing).
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  serial_if.slave   bus,
  output logic      tx,
  output tx_state_t state_dbg
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

`ifdef SERIAL_PARITY_EN
  localparam logic      PAR_EN     = 1'b1;
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam logic      PAR_EN     = 1'b0;
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  logic [1:0]  reg_sel;
  logic        wr_data;
  logic        rd_any;
  logic        rd_status;
  logic [31:0] status;
  logic [31:0] dout_q;
  logic        ovf_q;
  logic        unused_bits;

  logic        pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;

  tx_state_t   state, state_n;
  logic [7:0]  sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic        tx_n;
  logic        par_bit;

  assign reg_sel     = bus.addr[3:2];
  assign wr_data     = bus.sel && bus.we && (reg_sel == REG_DATA);
  assign rd_any      = bus.sel && bus.re;
  assign rd_status   = rd_any && (reg_sel == REG_STATUS);
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.din[31:8]};
  assign bus.dout    = dout_q;
  assign state_dbg   = state;

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data),
    .wdata (bus.din[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state != IDLE);
    status[ST_OVF]   = ovf_q;
    status[ST_PAR]   = PAR_EN;
  end

  // A STATUS load reports the pre-edge overflow and clears it, unless a new drop lands on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (rd_any) dout_q <= rd_status ? status : 32'd0;
      ovf_q <= (wr_data && fifo_full) || (ovf_q && !rd_status);
    end
  end

`ifdef SERIAL_PARITY_EN
  logic par_q, par_n;
  assign par_bit = par_q;
  always_ff @(posedge clock) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_n;
  end
`else
  assign par_bit = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    idx_n   = idx;
    pop     = 1'b0;
    tx_n    = 1'b1;
`ifdef SERIAL_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_rdata;
          cnt_n   = BIT_LAST;
          state_n = START;
`ifdef SERIAL_PARITY_EN
          par_n   = ^fifo_rdata;
`endif
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = BIT_LAST;
          idx_n   = '0;
          state_n = DATA;
        end else cnt_n = cnt - 1'b1;
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = BIT_LAST;
          sh_n  = sh >> 1;
          idx_n = idx + 1'b1;
          if (idx == 3'd7) state_n = AFTER_DATA;
        end else cnt_n = cnt - 1'b1;
      end
      PARITY: begin
        if (cnt == '0) begin
          cnt_n   = BIT_LAST;
          state_n = STOP;
        end else cnt_n = cnt - 1'b1;
      end
      STOP: begin
        if (cnt == '0) begin
          cnt_n   = BIT_LAST;
          state_n = IDLE;
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the next state so the line changes exactly on state edges.
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PARITY:  tx_n = par_bit;
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: queue-based line/status model plus a UART line decoder scoreboard.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int CLK_HZ = 8;
  localparam int BAUD   = 1;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DEPTH  = 16;
`ifdef SERIAL_PARITY_EN
  localparam int NBITS   = 11;
  localparam int PAR_BIT = 1;
`else
  localparam int NBITS   = 10;
  localparam int PAR_BIT = 0;
`endif
  localparam logic [31:0] PB = 32'(PAR_BIT) << 4;

  logic      clock = 1'b0;
  logic      reset = 1'b1;
  logic      tx;
  tx_state_t state_dbg;
  serial_if  bus();

  serial_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .tx        (tx),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: accepted bytes queue, and the frame in flight as a cycle offset.
  logic [7:0]  m_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  m_cur = '0;
  int          m_rem = 0;
  int          m_pos = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_dout = '0;

  function automatic logic exp_tx();
    int b;
    if (m_rem == 0) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (PAR_BIT == 1 && b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  always @(posedge clock) begin
    logic [31:0] st;
    logic        wr, st_rd, ovf_set, do_pop;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_rem  = 0;
      m_pos  = 0;
      m_ovf  = 1'b0;
      m_dout = '0;
    end else begin
      st      = {27'd0, PAR_BIT[0], m_ovf, m_rem > 0, m_q.size() == 0, m_q.size() == DEPTH};
      st_rd   = bus.sel && bus.re && (bus.addr[3:2] == 2'd1);
      wr      = bus.sel && bus.we && (bus.addr[3:2] == 2'd0);
      ovf_set = wr && (m_q.size() == DEPTH);
      do_pop  = (m_rem == 0) && (m_q.size() > 0);
      if (bus.sel && bus.re) m_dout = st_rd ? st : 32'd0;
      if (do_pop) begin
        m_cur = m_q.pop_front();
        m_rem = NBITS * DIV;
        m_pos = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        m_pos++;
      end
      if (wr && !ovf_set) begin
        m_q.push_back(bus.din[7:0]);
        exp_q.push_back(bus.din[7:0]);
      end
      m_ovf = ovf_set || (m_ovf && !st_rd);
    end
  end

  // Per-cycle checks and line decoder, sampled on the falling edge.
  bit         mon_on = 1'b0;
  bit         dec_busy = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = '0;
  int         cyc = 0;
  int         last_start = 0;
  int         last_gap = 0;

  always @(negedge clock) begin
    int b;
    cyc++;
    if (mon_on) begin
      check("tx", tx, exp_tx());
      check("dout", bus.dout, m_dout);
      check("busy", state_dbg != IDLE, m_rem > 0);
      if (reset) dec_busy = 1'b0;
      else if (!dec_busy) begin
        if (tx === 1'b0) begin
          dec_busy   = 1'b1;
          dec_cnt    = 0;
          last_gap   = cyc - last_start;
          last_start = cyc;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt % DIV == DIV / 2) begin
          b = dec_cnt / DIV;
          if (b >= 1 && b <= 8) dec_byte[b-1] = tx;
          if (PAR_BIT == 1 && b == 9 && exp_q.size() > 0) check("parity", tx, ^exp_q[0]);
          if (b == NBITS - 1) begin
            check("stop", tx, 1'b1);
            dec_busy = 1'b0;
            if (exp_q.size() == 0) check("rx_extra", 1'b1, 1'b0);
            else check("rx_byte", dec_byte, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_op(input logic s, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
    bus.sel = s; bus.we = w; bus.re = r; bus.addr = a; bus.din = d;
    tick(1);
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
  endtask

  task automatic store(input logic [7:0] v);
    logic [31:0] a, d;
    a = $urandom(); a[3:2] = 2'd0;
    d = $urandom(); d[7:0] = v;
    bus_op(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    logic [31:0] a;
    a = $urandom(); a[3:2] = 2'd1;
    bus_op(1'b1, 1'b0, 1'b1, a, 32'd0);
    check(tag, bus.dout, exp);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_rem != 0 || m_q.size() != 0 || exp_q.size() != 0 || dec_busy) && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_done", 32'(n < budget), 32'd1);
    tick(2);
  endtask

  initial begin
    logic [31:0] a, d;
    int op;
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.din = '0;
    reset = 1'b1;
    tick(1);
    mon_on = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);

    read_status("rst_status", 32'h2 | PB);
    check("rst_tx", tx, 1'b1);

    store(8'h55);
    tick(4);
    read_status("busy_status", 32'h6 | PB);
    drain(400);

    store(8'h41);
    store(8'h42);
    drain(400);
    check("b2b_gap", last_gap, NBITS * DIV + 1);

    store(8'h00);
    tick(3);
    for (int i = 0; i < DEPTH; i++) store(8'(i * 13 + 7));
    read_status("full_status", 32'h5 | PB);
    store(8'hEE);
    read_status("ovf_status", 32'hD | PB);
    read_status("ovf_cleared", 32'h5 | PB);
    drain(20 * 100);

    store(8'hF0);
    tick(1 + DIV + 3 * DIV);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_tx", tx, 1'b1);
    read_status("rst_mid_status", 32'h2 | PB);
    store(8'h0F);
    drain(400);

`ifdef SERIAL_PARITY_EN
    store(8'h07);
    tick(4);
    read_status("par_status", 32'h16);
    drain(400);
`endif

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      a = $urandom();
      d = $urandom();
      if (op <= 4) begin
        a[3:2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        bus_op(1'b1, 1'b1, 1'b0, a, d);
      end else if (op <= 7) begin
        bus_op(1'b1, 1'b0, 1'b1, a, d);
      end else if (op == 8) begin
        tick($urandom_range(0, 40));
      end else begin
        bus_op(1'b0, 1'b1, 1'b1, a, d);
      end
    end
    read_status("rand_status", {27'd0, PAR_BIT[0], m_ovf, m_rem > 0, m_q.size() == 0, m_q.size() == DEPTH});
    drain(30 * 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
